// File: rtl/instr_mem_pl_if.sv
// Bus bundle between the IF stage / program loader (master) and the
// pipelined instruction memory (slave).
interface instr_mem_pl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int LW_W   = 9
);
    // program port
    logic              prog_en;
    logic              prog_valid;
    logic [DATA_W-1:0] prog_data;
    logic              prog_ready;
    logic              load_ovf;
    logic [LW_W-1:0]   loaded_words;

    // fetch port
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              stall;
    logic              flush;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_addr;
    logic              instr_valid;
    logic              oob;

    modport master (
        output prog_en, prog_valid, prog_data,
        output fetch_req, fetch_addr, stall, flush,
        input  prog_ready, load_ovf, loaded_words,
        input  instr, instr_addr, instr_valid, oob
    );

    modport slave (
        input  prog_en, prog_valid, prog_data,
        input  fetch_req, fetch_addr, stall, flush,
        output prog_ready, load_ovf, loaded_words,
        output instr, instr_addr, instr_valid, oob
    );
endinterface

// File: rtl/instr_mem_pl.sv
// Loadable instruction store with synchronous one-cycle fetch, stall/flush
// handshake and a halt word for addresses outside the loaded image.
module instr_mem_pl #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 16,
    parameter int                DEPTH     = 256,
    parameter logic [DATA_W-1:0] HALT_WORD = 16'hFFFF
) (
    input  logic          clk,
    input  logic          rst,
    instr_mem_pl_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int LW_W  = IDX_W + 1;
    localparam int CMP_W = (ADDR_W > LW_W) ? ADDR_W : LW_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t            state_reg;
    logic [LW_W-1:0]   ptr_reg;
    logic [LW_W-1:0]   loaded_reg;
    logic              ovf_reg;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_reg;
    logic              halt_sel_reg;
    logic              oob_reg;
    logic              valid_reg;
    logic [ADDR_W-1:0] addr_reg;

    logic              ptr_has_room;
    logic              in_range;
    logic              run_active;
    logic              capture;
    logic              release_out;
    logic              mem_we;
    logic              mem_re;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    assign ptr_has_room = (ptr_reg < LW_W'(DEPTH));

    // Both sides are zero-extended so that any address at or above DEPTH
    // (including high PC bits) falls out of range.
    assign in_range = (CMP_W'(bus.fetch_addr) < CMP_W'(loaded_reg));

    // A program request in RUN takes the edge; no fetch is captured then.
    assign run_active  = (state_reg == RUN) && !bus.prog_en;
    assign capture     = run_active && bus.fetch_req && (!bus.stall || bus.flush);
    assign release_out = run_active && !capture && (bus.flush || !bus.stall);

    assign mem_we = (state_reg == LOAD) && bus.prog_en && bus.prog_valid && ptr_has_room;
    assign mem_re = capture && in_range;
    assign wr_idx = ptr_reg[IDX_W-1:0];
    assign rd_idx = bus.fetch_addr[IDX_W-1:0];

    // Block-RAM style store: no reset, registered read with enable so the
    // output holds through stalls without an extra capture register.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_idx] <= bus.prog_data;
        end
        if (mem_re) begin
            rd_data_reg <= mem[rd_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            loaded_reg   <= '0;
            ovf_reg      <= 1'b0;
            halt_sel_reg <= 1'b1;
            oob_reg      <= 1'b0;
            valid_reg    <= 1'b0;
            addr_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    valid_reg <= 1'b0;
                    if (bus.prog_en) begin
                        state_reg <= LOAD;
                        ptr_reg   <= '0;
                        ovf_reg   <= 1'b0;
                    end
                end

                LOAD: begin
                    valid_reg <= 1'b0;
                    if (!bus.prog_en) begin
                        state_reg  <= RUN;
                        loaded_reg <= ptr_reg;
                    end else if (bus.prog_valid) begin
                        if (ptr_has_room) begin
                            ptr_reg <= ptr_reg + 1'b1;
                        end else begin
                            ovf_reg <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (bus.prog_en) begin
                        state_reg  <= LOAD;
                        ptr_reg    <= '0;
                        loaded_reg <= '0;
                        ovf_reg    <= 1'b0;
                        valid_reg  <= 1'b0;
                    end else if (capture) begin
                        addr_reg     <= bus.fetch_addr;
                        valid_reg    <= 1'b1;
                        halt_sel_reg <= !in_range;
                        oob_reg      <= !in_range;
                    end else if (release_out) begin
                        valid_reg <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.prog_ready   = (state_reg == LOAD) && ptr_has_room;
    assign bus.load_ovf     = ovf_reg;
    assign bus.loaded_words = loaded_reg;
    assign bus.instr        = halt_sel_reg ? HALT_WORD : rd_data_reg;
    assign bus.instr_addr   = addr_reg;
    assign bus.instr_valid  = valid_reg;
    assign bus.oob          = oob_reg;

endmodule

// File: tb/tb_instr_mem_pl.sv
// Directed bench for instr_mem_pl: a DEPTH=256 instance for the main flow
// and a DEPTH=4 instance for load overflow.
module tb_instr_mem_pl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_mem_pl_if #(.DATA_W(16), .ADDR_W(16), .LW_W(9)) bus_a ();
    instr_mem_pl_if #(.DATA_W(16), .ADDR_W(16), .LW_W(3)) bus_b ();

    instr_mem_pl #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .HALT_WORD(16'hFFFF)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    instr_mem_pl #(.DATA_W(16), .ADDR_W(16), .DEPTH(4), .HALT_WORD(16'hFFFF)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    logic [15:0] img [7] = '{16'h10DC, 16'h1087, 16'hC604, 16'h1140, 16'h16FF, 16'h11C2, 16'hFFFF};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick;
        tick;
        total++; if (bus_a.prog_ready !== 1'b0) begin bad++; $display("FAIL rst_prog_ready got=%b want=0", bus_a.prog_ready); end
        total++; if (bus_a.loaded_words !== 9'd0) begin bad++; $display("FAIL rst_loaded got=%0d want=0", bus_a.loaded_words); end
        total++; if (bus_a.load_ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b want=0", bus_a.load_ovf); end
        total++; if (bus_a.instr !== 16'hFFFF) begin bad++; $display("FAIL rst_instr got=%h want=ffff", bus_a.instr); end
        total++; if (bus_a.instr_addr !== 16'h0000) begin bad++; $display("FAIL rst_addr got=%h want=0000", bus_a.instr_addr); end
        total++; if (bus_a.instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus_a.instr_valid); end
        total++; if (bus_a.oob !== 1'b0) begin bad++; $display("FAIL rst_oob got=%b want=0", bus_a.oob); end
        total++; if (bus_b.instr !== 16'hFFFF) begin bad++; $display("FAIL rst_b_instr got=%h want=ffff", bus_b.instr); end
        $display("reset checked");
        rst = 1'b0;
        tick;
    endtask

    task automatic test_load_fetch;
        bus_a.prog_en = 1'b1;
        tick;
        total++; if (bus_a.prog_ready !== 1'b1) begin bad++; $display("FAIL load_ready got=%b want=1", bus_a.prog_ready); end
        for (int i = 0; i < 7; i++) begin
            bus_a.prog_valid = 1'b1;
            bus_a.prog_data  = img[i];
            tick;
            $display("load beat %0d data=%h", i, img[i]);
        end
        bus_a.prog_valid = 1'b0;
        bus_a.prog_en    = 1'b0;
        tick;
        total++; if (bus_a.loaded_words !== 9'd7) begin bad++; $display("FAIL loaded_words got=%0d want=7", bus_a.loaded_words); end
        total++; if (bus_a.load_ovf !== 1'b0) begin bad++; $display("FAIL load_ovf got=%b want=0", bus_a.load_ovf); end
        total++; if (bus_a.prog_ready !== 1'b0) begin bad++; $display("FAIL run_ready got=%b want=0", bus_a.prog_ready); end
        total++; if (bus_a.instr_valid !== 1'b0) begin bad++; $display("FAIL run_valid0 got=%b want=0", bus_a.instr_valid); end
        bus_a.fetch_req = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus_a.fetch_addr = 16'(i);
            tick;
            $display("fetch addr=%0d instr=%h valid=%b oob=%b", i, bus_a.instr, bus_a.instr_valid, bus_a.oob);
            total++; if (bus_a.instr !== img[i]) begin bad++; $display("FAIL b2b_instr%0d got=%h want=%h", i, bus_a.instr, img[i]); end
            total++; if (bus_a.instr_addr !== 16'(i)) begin bad++; $display("FAIL b2b_addr%0d got=%h want=%0d", i, bus_a.instr_addr, i); end
            total++; if (bus_a.instr_valid !== 1'b1 || bus_a.oob !== 1'b0) begin bad++; $display("FAIL b2b_flags%0d got=%b%b want=10", i, bus_a.instr_valid, bus_a.oob); end
        end
    endtask

    task automatic test_oob;
        bus_a.fetch_req  = 1'b1;
        bus_a.fetch_addr = 16'd7;
        tick;
        $display("fetch addr=7 instr=%h oob=%b", bus_a.instr, bus_a.oob);
        total++; if (bus_a.instr !== 16'hFFFF || bus_a.oob !== 1'b1) begin bad++; $display("FAIL oob7 got=%h/%b want=ffff/1", bus_a.instr, bus_a.oob); end
        total++; if (bus_a.instr_addr !== 16'd7 || bus_a.instr_valid !== 1'b1) begin bad++; $display("FAIL oob7_addr got=%h/%b want=0007/1", bus_a.instr_addr, bus_a.instr_valid); end
        bus_a.fetch_addr = 16'h1234;
        tick;
        $display("fetch addr=1234 instr=%h oob=%b", bus_a.instr, bus_a.oob);
        total++; if (bus_a.instr !== 16'hFFFF || bus_a.oob !== 1'b1) begin bad++; $display("FAIL oob1234 got=%h/%b want=ffff/1", bus_a.instr, bus_a.oob); end
        total++; if (bus_a.instr_addr !== 16'h1234) begin bad++; $display("FAIL oob1234_addr got=%h want=1234", bus_a.instr_addr); end
        bus_a.fetch_req = 1'b0;
        tick;
        total++; if (bus_a.instr_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b want=0", bus_a.instr_valid); end
        total++; if (bus_a.instr !== 16'hFFFF || bus_a.oob !== 1'b1) begin bad++; $display("FAIL idle_hold got=%h/%b want=ffff/1", bus_a.instr, bus_a.oob); end
    endtask

    task automatic test_stall;
        bus_a.fetch_req  = 1'b1;
        bus_a.fetch_addr = 16'd2;
        tick;
        total++; if (bus_a.instr !== 16'hC604 || bus_a.oob !== 1'b0) begin bad++; $display("FAIL stall_pre got=%h/%b want=c604/0", bus_a.instr, bus_a.oob); end
        bus_a.stall      = 1'b1;
        bus_a.fetch_addr = 16'd3;
        for (int k = 0; k < 3; k++) begin
            tick;
            $display("stall cycle %0d instr=%h addr=%h valid=%b", k, bus_a.instr, bus_a.instr_addr, bus_a.instr_valid);
            total++; if (bus_a.instr !== 16'hC604) begin bad++; $display("FAIL stall_instr%0d got=%h want=c604", k, bus_a.instr); end
            total++; if (bus_a.instr_addr !== 16'd2 || bus_a.instr_valid !== 1'b1) begin bad++; $display("FAIL stall_hold%0d got=%h/%b want=0002/1", k, bus_a.instr_addr, bus_a.instr_valid); end
        end
        bus_a.stall = 1'b0;
        tick;
        total++; if (bus_a.instr !== 16'h1140 || bus_a.instr_addr !== 16'd3) begin bad++; $display("FAIL stall_post got=%h@%h want=1140@0003", bus_a.instr, bus_a.instr_addr); end
    endtask

    task automatic test_flush;
        bus_a.fetch_req  = 1'b1;
        bus_a.fetch_addr = 16'd5;
        bus_a.stall      = 1'b1;
        bus_a.flush      = 1'b1;
        tick;
        $display("flush redirect addr=5 instr=%h valid=%b", bus_a.instr, bus_a.instr_valid);
        total++; if (bus_a.instr !== 16'h11C2 || bus_a.instr_valid !== 1'b1) begin bad++; $display("FAIL flush_redirect got=%h/%b want=11c2/1", bus_a.instr, bus_a.instr_valid); end
        total++; if (bus_a.instr_addr !== 16'd5) begin bad++; $display("FAIL flush_addr got=%h want=0005", bus_a.instr_addr); end
        bus_a.fetch_req = 1'b0;
        bus_a.stall     = 1'b0;
        tick;
        $display("flush alone valid=%b", bus_a.instr_valid);
        total++; if (bus_a.instr_valid !== 1'b0) begin bad++; $display("FAIL flush_kill got=%b want=0", bus_a.instr_valid); end
        total++; if (bus_a.instr !== 16'h11C2) begin bad++; $display("FAIL flush_hold got=%h want=11c2", bus_a.instr); end
        bus_a.flush = 1'b0;
    endtask

    task automatic test_overflow;
        bus_b.prog_en = 1'b1;
        tick;
        for (int i = 0; i < 6; i++) begin
            total++; if (bus_b.prog_ready !== (i < 4)) begin bad++; $display("FAIL ovf_ready%0d got=%b want=%b", i, bus_b.prog_ready, (i < 4)); end
            total++; if (bus_b.load_ovf !== (i >= 5)) begin bad++; $display("FAIL ovf_flag%0d got=%b want=%b", i, bus_b.load_ovf, (i >= 5)); end
            bus_b.prog_valid = 1'b1;
            bus_b.prog_data  = 16'hA0 + 16'(i);
            tick;
            $display("depth4 offer %0d data=%h", i, 16'hA0 + 16'(i));
        end
        bus_b.prog_valid = 1'b0;
        bus_b.prog_en    = 1'b0;
        tick;
        total++; if (bus_b.loaded_words !== 3'd4) begin bad++; $display("FAIL ovf_loaded got=%0d want=4", bus_b.loaded_words); end
        total++; if (bus_b.load_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", bus_b.load_ovf); end
        bus_b.fetch_req  = 1'b1;
        bus_b.fetch_addr = 16'd3;
        tick;
        total++; if (bus_b.instr !== 16'h00A3 || bus_b.oob !== 1'b0) begin bad++; $display("FAIL ovf_fetch3 got=%h/%b want=00a3/0", bus_b.instr, bus_b.oob); end
        bus_b.fetch_addr = 16'd4;
        tick;
        total++; if (bus_b.instr !== 16'hFFFF || bus_b.oob !== 1'b1) begin bad++; $display("FAIL ovf_fetch4 got=%h/%b want=ffff/1", bus_b.instr, bus_b.oob); end
        bus_b.fetch_req = 1'b0;
        bus_b.prog_en   = 1'b1;
        tick;
        total++; if (bus_b.load_ovf !== 1'b0 || bus_b.loaded_words !== 3'd0) begin bad++; $display("FAIL ovf_reload got=%b/%0d want=0/0", bus_b.load_ovf, bus_b.loaded_words); end
        bus_b.prog_en = 1'b0;
        tick;
    endtask

    task automatic test_reset_midrun;
        bus_a.fetch_req  = 1'b1;
        bus_a.fetch_addr = 16'd1;
        tick;
        total++; if (bus_a.instr !== 16'h1087 || bus_a.instr_valid !== 1'b1) begin bad++; $display("FAIL midrun_pre got=%h/%b want=1087/1", bus_a.instr, bus_a.instr_valid); end
        bus_a.fetch_req = 1'b0;
        #2 rst = 1'b1;
        #1;
        $display("async reset in run valid=%b instr=%h", bus_a.instr_valid, bus_a.instr);
        total++; if (bus_a.instr_valid !== 1'b0 || bus_a.instr !== 16'hFFFF) begin bad++; $display("FAIL midrun_async got=%b/%h want=0/ffff", bus_a.instr_valid, bus_a.instr); end
        total++; if (bus_a.loaded_words !== 9'd0) begin bad++; $display("FAIL midrun_loaded got=%0d want=0", bus_a.loaded_words); end
        #1 rst = 1'b0;
        tick;
    endtask

    task automatic test_reset_midload;
        bus_a.prog_en = 1'b1;
        tick;
        for (int i = 0; i < 2; i++) begin
            bus_a.prog_valid = 1'b1;
            bus_a.prog_data  = 16'h5550 + 16'(i);
            tick;
        end
        bus_a.prog_data = 16'h5552;
        #2 rst = 1'b1;
        bus_a.prog_en    = 1'b0;
        bus_a.prog_valid = 1'b0;
        #1;
        $display("reset during third beat ready=%b loaded=%0d", bus_a.prog_ready, bus_a.loaded_words);
        total++; if (bus_a.prog_ready !== 1'b0) begin bad++; $display("FAIL midload_ready got=%b want=0", bus_a.prog_ready); end
        total++; if (bus_a.loaded_words !== 9'd0) begin bad++; $display("FAIL midload_loaded got=%0d want=0", bus_a.loaded_words); end
        #1 rst = 1'b0;
        tick;
        total++; if (bus_a.prog_ready !== 1'b0) begin bad++; $display("FAIL midload_idle got=%b want=0", bus_a.prog_ready); end
        bus_a.prog_en = 1'b1;
        tick;
        bus_a.prog_valid = 1'b1;
        bus_a.prog_data  = 16'h1111;
        tick;
        bus_a.prog_data  = 16'h2222;
        tick;
        bus_a.prog_valid = 1'b0;
        bus_a.prog_en    = 1'b0;
        tick;
        total++; if (bus_a.loaded_words !== 9'd2) begin bad++; $display("FAIL reload_loaded got=%0d want=2", bus_a.loaded_words); end
        bus_a.fetch_req  = 1'b1;
        bus_a.fetch_addr = 16'd2;
        tick;
        $display("fetch addr=2 after reload instr=%h oob=%b", bus_a.instr, bus_a.oob);
        total++; if (bus_a.instr !== 16'hFFFF || bus_a.oob !== 1'b1) begin bad++; $display("FAIL reload_oob got=%h/%b want=ffff/1", bus_a.instr, bus_a.oob); end
        bus_a.fetch_addr = 16'd1;
        tick;
        total++; if (bus_a.instr !== 16'h2222 || bus_a.oob !== 1'b0) begin bad++; $display("FAIL reload_fetch1 got=%h/%b want=2222/0", bus_a.instr, bus_a.oob); end
        bus_a.fetch_req = 1'b0;
        tick;
    endtask

    initial begin
        bus_a.prog_en = 1'b0; bus_a.prog_valid = 1'b0; bus_a.prog_data = '0;
        bus_a.fetch_req = 1'b0; bus_a.fetch_addr = '0; bus_a.stall = 1'b0; bus_a.flush = 1'b0;
        bus_b.prog_en = 1'b0; bus_b.prog_valid = 1'b0; bus_b.prog_data = '0;
        bus_b.fetch_req = 1'b0; bus_b.fetch_addr = '0; bus_b.stall = 1'b0; bus_b.flush = 1'b0;

        test_reset;
        test_load_fetch;
        test_oob;
        test_stall;
        test_flush;
        test_overflow;
        test_reset_midrun;
        test_reset_midload;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_mem_pl.md
# instr_mem_pl

Parametrised, loadable, pipelined instruction memory for the IF stage of the RISC pipeline. It replaces a fixed, combinationally read ROM with a synchronous-read store. The store is filled at run time through a streaming program port. Fetches are served with one-cycle latency and a stall/flush handshake. Addresses beyond the loaded image return a halt word.

## Interface
- DATA_W, 16, instruction width
- ADDR_W, 16, fetch address width
- DEPTH, 256, number of instruction words (≥2)
- HALT_WORD, 16'hFFFF, word returned for unloaded or out-of-range addresses
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- prog_en  in  1  program-mode request (level)
- prog_valid  in  1  program word present
- prog_data  in  DATA_W  program word
- prog_ready  out  1  program word can be accepted
- load_ovf  out  1  sticky: a word was offered while the store was full
- loaded_words  out  clog2(DEPTH)+1  size of the current valid image
- fetch_req  in  1  fetch request from IF
- fetch_addr  in  ADDR_W  word address (PC)
- stall  in  1  hold current output
- flush  in  1  discard current output
- instr  out  DATA_W  fetched instruction
- instr_addr  out  ADDR_W  address of instr
- instr_valid  out  1  instr is a live fetch result
- oob  out  1  instr_addr ≥ loaded_words (instr is HALT_WORD)

## Operation
- Storage: DEPTH×DATA_W array. It is not reset; contents survive rst but are inaccessible until a new load completes.
- FSM states: IDLE, LOAD, RUN. Reset enters IDLE.
  - IDLE: fetches ignored. prog_en=1 → LOAD.
  - LOAD: ptr starts at 0. prog_ready = (ptr < DEPTH).
    - Beat accepted when prog_en & prog_valid & prog_ready: mem[ptr] ← prog_data, ptr++.
    - prog_valid & prog_en with ptr == DEPTH: word dropped, load_ovf ← 1.
    - prog_en=0 → RUN, with loaded_words ← ptr at the same edge.
  - RUN: serves fetches. prog_en=1 → LOAD, with ptr ← 0, loaded_words ← 0 and instr_valid ← 0.
- load_ovf clears on entry to LOAD or on rst.
- Fetch in RUN, evaluated per edge, in priority order:
  1. capture = fetch_req & (!stall | flush). On capture:
     - instr_addr ← fetch_addr and instr_valid ← 1.
     - If fetch_addr < loaded_words (unsigned, zero-extended compare; fetch_addr ≥ DEPTH is always out of range): instr ← mem[fetch_addr] and oob ← 0.
     - Otherwise: instr ← HALT_WORD and oob ← 1.
  2. Else if flush | !stall: instr_valid ← 0. instr, instr_addr and oob hold.
  3. Else (stall without flush): all outputs hold.
- flush dominates stall. A fetch_req together with flush captures the redirect target.
- In IDLE and LOAD, instr_valid is forced 0 and fetch_req is ignored.

## Timing
- Reset values:
  - state IDLE, ptr 0, loaded_words 0, load_ovf 0
  - prog_ready 0
  - instr HALT_WORD, instr_addr 0, instr_valid 0, oob 0
- prog_ready is combinational from state and ptr. It is high in the first cycle after the edge that samples prog_en=1.
- Fetch latency is 1 cycle: the address captured at edge N appears on instr/instr_valid after edge N.
- A back-to-back fetch_req without stall gives one instruction per cycle.
- First fetch can be captured in the first RUN cycle. Its data appears one cycle later.
- stall held k cycles keeps instr and instr_valid constant for k cycles.
- A write and a fetch never occur in the same cycle, because the states are exclusive.
- rst mid-LOAD: the partial image is discarded (loaded_words 0) and the state returns to IDLE.
- rst mid-RUN: the output is invalidated asynchronously.

## Test plan
- Load 0x10DC, 0x1087, 0xC604, 0x1140, 0x16FF, 0x11C2, 0xFFFF, then drop prog_en → loaded_words=7. Fetch addresses 0..6 back-to-back → instr 0x10DC…0xFFFF, one per cycle, 1-cycle latency, oob=0.
- After the 7-word load, fetch address 7 → instr=0xFFFF, oob=1. Fetch address 0x1234 → instr=0xFFFF, oob=1.
- Fetch address 2, then stall 3 cycles while fetch_req=1 with address 3 → instr=0xC604 held 3 cycles, then address 3 is captured.
- Stall=1 and flush=1 with fetch_req=1 at address 5 → next cycle instr=0x11C2, valid=1. Flush alone → valid=0 next cycle.
- DEPTH=4: offer 6 words → prog_ready low after 4, load_ovf=1, loaded_words=4.
- Assert rst during the 3rd load beat → IDLE, loaded_words=0. A following load of 2 words followed by a fetch at address 2 → oob=1.
